// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//
// Shares port B of a simple dual-port block RAM (1-cycle registered read,
// old data returned on a same-address collision) between two requesters
// using round-robin arbitration and a valid/ready handshake. Read data is
// steered back to the requester that issued the read through a one-deep
// tagged response stage. After reset the block can optionally sweep every
// RAM location with CLEAR_VALUE before it starts accepting traffic.
//
// Ports:
//   clock, rst              single clock, synchronous active-high reset
//   reqN_valid/wren/addr/wrdata   request from client N (N = 0,1)
//   reqN_ready              request accepted this cycle (combinational)
//   reqN_rdvalid/rddata     read response for client N, one cycle after accept
//   ram_address/wrdata/wren drive to RAM port B
//   ram_rddata              registered read data from RAM port B
//   init_done               high once the clear sweep has finished
module dpram_port_arbiter #(
  parameter int                      DATA_WIDTH     = 8,
  parameter int                      ADDR_WIDTH     = 7,
  parameter bit                      CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = '0
) (
  input  logic                  clock,
  input  logic                  rst,

  input  logic                  req0_valid,
  input  logic                  req0_wren,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wrdata,
  output logic                  req0_ready,
  output logic                  req0_rdvalid,
  output logic [DATA_WIDTH-1:0] req0_rddata,

  input  logic                  req1_valid,
  input  logic                  req1_wren,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wrdata,
  output logic                  req1_ready,
  output logic                  req1_rdvalid,
  output logic [DATA_WIDTH-1:0] req1_rddata,

  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wrdata,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_rddata,

  output logic                  init_done
);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = '1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clear_count;
  logic                  last_grant;
  logic                  pend_valid;
  logic                  pend_id;

  logic                  grant_valid;
  logic                  grant_id;
  logic                  run_active;
  logic                  transfer;
  logic                  sel_wren;

  // State register; reset lands in CLEAR or RUN depending on whether a
  // clear sweep is wanted.
  always_ff @(posedge clock) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state <= ST_CLEAR;
      else                state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Leave CLEAR right after the write to the last address has been issued.
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clear_count == CLEAR_LAST) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = state;
    endcase
  end

  // Round-robin arbitration: on a tie the requester that did not win last
  // time is served. last_grant resets to 1 so req0 wins the first tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // rst masks every handshake output so nothing is accepted or written in
  // the reset cycle, whatever state the register still holds.
  assign run_active = (state == ST_RUN) && !rst;
  assign transfer   = run_active && grant_valid;
  assign sel_wren   = grant_id ? req1_wren : req0_wren;

  assign req0_ready = transfer && !grant_id;
  assign req1_ready = transfer &&  grant_id;

  // RAM port B drive: sweep during CLEAR, otherwise follow the granted
  // requester. With no grant the address idles on req0_addr.
  always_comb begin
    ram_address = req0_addr;
    ram_wrdata  = req0_wrdata;
    ram_wren    = 1'b0;
    if (state == ST_CLEAR) begin
      ram_address = clear_count;
      ram_wrdata  = CLEAR_VALUE;
      ram_wren    = !rst;
    end else begin
      if (grant_valid && grant_id) begin
        ram_address = req1_addr;
        ram_wrdata  = req1_wrdata;
      end
      ram_wren = transfer && sel_wren;
    end
  end

  // Sweep counter, round-robin history and the tagged read-response stage.
  // The RAM's registered read lines up with pend_valid one cycle later.
  always_ff @(posedge clock) begin
    if (rst) begin
      clear_count <= '0;
      last_grant  <= 1'b1;
      pend_valid  <= 1'b0;
      pend_id     <= 1'b0;
    end else begin
      if (state == ST_CLEAR) clear_count <= clear_count + 1'b1;
      if (transfer) begin
        last_grant <= grant_id;
        pend_id    <= grant_id;
      end
      pend_valid <= transfer && !sel_wren;
    end
  end

  // A response pending across a reset is dropped.
  assign req0_rdvalid = pend_valid && !pend_id && !rst;
  assign req1_rdvalid = pend_valid &&  pend_id && !rst;
  assign req0_rddata  = ram_rddata;
  assign req1_rddata  = ram_rddata;

  // RUN is only left through rst, so this stays high until the next reset.
  assign init_done = (state == ST_RUN) && !rst;

endmodule
